cache_line_addr_gen: RTL

- Inverse of the cache set control unit's address split: rebuilds a byte address from tag, index, offset and the associativity mode.
- Issues that address as a wrapping, beat-by-beat line burst toward memory, for refill and writeback.
- Sits between the cache controller (request side) and the memory port (valid/ready side).
- One request in flight; the mode is latched per request.

---
 rtl/cache_line_addr_gen_pkg.sv | 40 ++++
 rtl/cache_line_addr_gen_if.sv | 30 +++
 rtl/cache_line_addr_gen_compose.sv | 41 ++++
 rtl/cache_line_addr_gen.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cache_line_addr_gen_pkg.sv
// Shared widths, mode encodings and FSM state type for the cache line address generator.
// Per-mode tag/index widths always sum to 28, leaving the 4-bit line offset below them.
package cache_cfg_pkg;

    localparam int WIDTH      = 32;
    localparam int MODES      = 4;
    localparam int SEL_W      = MODES - 2;
    localparam int LINE_BYTES = 16;
    localparam int BEAT_BYTES = 4;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
    localparam int CNT_W      = $clog2(BEATS);
    localparam int BEAT_SH    = $clog2(BEAT_BYTES);

    localparam int TAG_W = 19;
    localparam int IDX_W = 12;
    localparam int OFF_W = 4;

    localparam int TAG_W_DM = 16;
    localparam int TAG_W_2W = 17;
    localparam int TAG_W_4W = 18;
    localparam int TAG_W_8W = 19;

    localparam int IDX_W_DM = 12;
    localparam int IDX_W_2W = 11;
    localparam int IDX_W_4W = 10;
    localparam int IDX_W_8W = 9;

    typedef enum logic [SEL_W-1:0] {
        MODE_DM = 2'b00,
        MODE_2W = 2'b01,
        MODE_4W = 2'b10,
        MODE_8W = 2'b11
    } mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/cache_line_addr_gen_if.sv
// Request-side and memory-side signals of the line address generator.
// master = cache controller / memory model view, slave = generator view.
interface cache_line_addr_gen_if;
    import cache_cfg_pkg::*;

    logic [SEL_W-1:0] selection_signal;
    logic             req_valid;
    logic             req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_index;
    logic [OFF_W-1:0] req_offset;
    logic             mem_valid;
    logic             mem_ready;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_last;
    logic             busy;
    logic             done;
    logic             req_err;

    modport master (
        output selection_signal, req_valid, req_tag, req_index, req_offset, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_last, busy, done, req_err
    );

    modport slave (
        input  selection_signal, req_valid, req_tag, req_index, req_offset, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_last, busy, done, req_err
    );

endinterface

// File: rtl/cache_line_addr_gen_compose.sv
// Rebuilds a byte address from tag/index/offset for a given associativity mode and flags
// requests whose tag or index carry bits outside that mode's field widths.
module cache_addr_compose
    import cache_cfg_pkg::*;
(
    input  mode_t            mode,
    input  logic [TAG_W-1:0] tag,
    input  logic [IDX_W-1:0] index,
    input  logic [OFF_W-1:0] off,
    output logic [WIDTH-1:0] addr,
    output logic             fmt_err
);

    always_comb begin
        addr    = '0;
        fmt_err = 1'b0;
        case (mode)
            MODE_DM: begin
                addr    = {tag[TAG_W_DM-1:0], index[IDX_W_DM-1:0], off};
                fmt_err = |tag[TAG_W-1:TAG_W_DM];
            end
            MODE_2W: begin
                addr    = {tag[TAG_W_2W-1:0], index[IDX_W_2W-1:0], off};
                fmt_err = (|tag[TAG_W-1:TAG_W_2W]) | (|index[IDX_W-1:IDX_W_2W]);
            end
            MODE_4W: begin
                addr    = {tag[TAG_W_4W-1:0], index[IDX_W_4W-1:0], off};
                fmt_err = (|tag[TAG_W-1:TAG_W_4W]) | (|index[IDX_W-1:IDX_W_4W]);
            end
            MODE_8W: begin
                addr    = {tag[TAG_W_8W-1:0], index[IDX_W_8W-1:0], off};
                fmt_err = |index[IDX_W-1:IDX_W_8W];
            end
            default: begin
                addr    = '0;
                fmt_err = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cache_line_addr_gen.sv
// Line burst address generator: accepts one refill/writeback request and walks the line
// beat by beat, wrapping inside the line from the critical word.
//
// state | meaning
// IDLE  | ready for a request; malformed requests are rejected with req_err
// BURST | presenting beat addresses to memory until the final beat handshakes
module cache_line_addr_gen
    import cache_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    cache_line_addr_gen_if.slave bus
);

    state_t           state_q, state_d;
    mode_t            mode_q, mode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             ready_q, ready_d;

    mode_t            c_mode;
    logic [TAG_W-1:0] c_tag;
    logic [IDX_W-1:0] c_idx;
    logic [OFF_W-1:0] c_off;
    logic [WIDTH-1:0] c_addr;
    logic             c_err;
    logic [CNT_W-1:0] beat_nxt;

    // One composer serves both the live request (IDLE) and the latched line (BURST), so
    // every beat is rebuilt from the latched fields and upper bits cannot drift.
    assign beat_nxt = start_q + cnt_q + CNT_W'(1);

    always_comb begin
        c_mode = mode_q;
        c_tag  = tag_q;
        c_idx  = idx_q;
        c_off  = {beat_nxt, {BEAT_SH{1'b0}}};
        if (state_q == IDLE) begin
            c_mode = mode_t'(bus.selection_signal);
            c_tag  = bus.req_tag;
            c_idx  = bus.req_index;
            c_off  = bus.req_offset & ~OFF_W'(BEAT_BYTES - 1);
        end
    end

    cache_addr_compose u_compose (
        .mode    (c_mode),
        .tag     (c_tag),
        .index   (c_idx),
        .off     (c_off),
        .addr    (c_addr),
        .fmt_err (c_err)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    if (c_err) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = BURST;
                        mode_d  = c_mode;
                        tag_d   = bus.req_tag;
                        idx_d   = bus.req_index;
                        start_d = c_off[OFF_W-1:BEAT_SH];
                        cnt_d   = '0;
                        addr_d  = c_addr;
                        valid_d = 1'b1;
                        last_d  = (CNT_W'(BEATS - 1) == '0);
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
            end
            BURST: begin
                if (bus.mem_ready) begin
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d  = cnt_q + CNT_W'(1);
                        addr_d = c_addr;
                        last_d = ((cnt_q + CNT_W'(1)) == CNT_W'(BEATS - 1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            mode_q  <= MODE_DM;
            tag_q   <= '0;
            idx_q   <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_last  = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.req_err   = err_q;

endmodule
